// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locking arbiter sharing the FIFO write port
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            wreq,
    input  logic [NUM_REQ-1:0]            wlast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
    input  logic                          wfull,
    output logic [NUM_REQ-1:0]            wgnt,
    output logic                          wclken,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          burst_err
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state;
    logic [OW-1:0] last_owner, pick, idx;
    logic [CW-1:0] beat_cnt;
    logic          cap;
    always_comb begin
        pick = '0;
        idx  = '0;
        // descending scan so the nearest requester after last_owner wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = OW'((int'(last_owner) + k) % NUM_REQ);
            if (wreq[idx]) pick = idx;
        end
    end
    assign busy   = state == BUSY;
    assign wclken = busy && wreq[owner] && !wfull;
    assign wgnt   = busy ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0;
    assign wdata  = wdata_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign cap    = beat_cnt == CW'(MAX_BURST - 1);
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            burst_err  <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            if (state == IDLE) begin
                if (|wreq) begin
                    owner    <= pick;
                    beat_cnt <= '0;
                    state    <= BUSY;
                end
            end else if (wclken) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (wlast[owner] || cap) begin
                    last_owner <= owner;
                    state      <= IDLE;
                    burst_err  <= !wlast[owner];
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (MAX_BURST=4)
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  wreq, wlast;
    logic [31:0] wdata_in;
    logic        wfull;
    logic [3:0]  wgnt;
    logic        wclken;
    logic [7:0]  wdata;
    logic [1:0]  owner;
    logic        busy, burst_err;
    int          tests = 0;
    int          fails = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .wreq(wreq), .wlast(wlast), .wdata_in(wdata_in),
        .wfull(wfull), .wgnt(wgnt), .wclken(wclken), .wdata(wdata), .owner(owner),
        .busy(busy), .burst_err(burst_err)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic idle_step(input string tag, input logic berr);
        @(negedge wclk);
        chk({tag, " wgnt"}, 32'(wgnt), 0);
        chk({tag, " wclken"}, 32'(wclken), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " burst_err"}, 32'(burst_err), 32'(berr));
        tick();
    endtask

    task automatic beat_step(input string tag, input int own, input logic [7:0] d);
        @(negedge wclk);
        chk({tag, " wgnt"}, 32'(wgnt), 32'(1) << own);
        chk({tag, " owner"}, 32'(owner), 32'(own));
        chk({tag, " wclken"}, 32'(wclken), 1);
        chk({tag, " wdata"}, 32'(wdata), 32'(d));
        chk({tag, " burst_err"}, 32'(burst_err), 0);
        tick();
    endtask

    task automatic stall_step(input string tag, input int own);
        @(negedge wclk);
        chk({tag, " wgnt"}, 32'(wgnt), 32'(1) << own);
        chk({tag, " wclken"}, 32'(wclken), 0);
        chk({tag, " busy"}, 32'(busy), 1);
        tick();
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        wdata_in[i*8 +: 8] = v;
    endtask

    initial begin
        wrst = 1'b1; wreq = '0; wlast = '0; wdata_in = '0; wfull = 1'b0;
        tick();
        @(negedge wclk);
        chk("rst owner", 32'(owner), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst wgnt", 32'(wgnt), 0);
        chk("rst wclken", 32'(wclken), 0);
        chk("rst burst_err", 32'(burst_err), 0);
        tick();

        // all four request single-beat packets: rotation 0,1,2,3,0
        wrst = 1'b0; wreq = 4'b1111; wlast = 4'b1111; wdata_in = 32'hA3A2A1A0;
        for (int g = 0; g < 5; g++) begin
            idle_step("rr idle", 1'b0);
            beat_step("rr beat", g % 4, 8'hA0 + 8'(g % 4));
        end
        wreq = '0; wlast = '0;

        // packet lock: requester 2 holds for 3 beats while 1 waits
        wreq = 4'b0100;
        idle_step("lock idle", 1'b0);
        wreq = 4'b0110; set_data(2, 8'h20);
        beat_step("lock b1", 2, 8'h20);
        set_data(2, 8'h21);
        beat_step("lock b2", 2, 8'h21);
        wlast = 4'b0100; set_data(2, 8'h22);
        beat_step("lock b3", 2, 8'h22);
        wreq = 4'b0010; wlast = 4'b0010; set_data(1, 8'h11);
        idle_step("lock gap", 1'b0);
        beat_step("lock next", 1, 8'h11);
        wreq = '0; wlast = '0;

        // wfull stall mid-packet
        wreq = 4'b0001; set_data(0, 8'h30);
        idle_step("full idle", 1'b0);
        beat_step("full b1", 0, 8'h30);
        wfull = 1'b1; set_data(0, 8'h31);
        for (int s = 0; s < 5; s++) stall_step("full stall", 0);
        wfull = 1'b0;
        beat_step("full b2", 0, 8'h31);
        wlast = 4'b0001; set_data(0, 8'h32);
        beat_step("full b3", 0, 8'h32);
        wreq = '0; wlast = '0;
        idle_step("full done", 1'b0);

        // 6-beat stream exceeds MAX_BURST=4
        wreq = 4'b1000;
        idle_step("burst idle", 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_data(3, 8'h40 + 8'(b));
            beat_step("burst beat", 3, 8'h40 + 8'(b));
        end
        set_data(3, 8'h44);
        idle_step("burst release", 1'b1);
        beat_step("burst b5", 3, 8'h44);
        wlast = 4'b1000; set_data(3, 8'h45);
        beat_step("burst b6", 3, 8'h45);
        wreq = '0; wlast = '0;
        idle_step("burst done", 1'b0);

        // owner idles without wlast; requester 1 must wait
        wreq = 4'b0001; set_data(0, 8'h60);
        idle_step("hold idle", 1'b0);
        beat_step("hold b1", 0, 8'h60);
        wreq = 4'b0010;
        for (int s = 0; s < 10; s++) stall_step("hold gap", 0);
        wreq = 4'b0011; wlast = 4'b0001; set_data(0, 8'h61); set_data(1, 8'h71);
        beat_step("hold b2", 0, 8'h61);
        wreq = 4'b0010; wlast = 4'b0010;
        idle_step("hold idle2", 1'b0);
        beat_step("hold next", 1, 8'h71);
        wreq = '0; wlast = '0;

        // reset mid-packet restores last_owner so requester 0 wins over 3
        wreq = 4'b0100; set_data(2, 8'h50);
        idle_step("mrst idle", 1'b0);
        beat_step("mrst b1", 2, 8'h50);
        wrst = 1'b1; set_data(2, 8'h51);
        beat_step("mrst b2", 2, 8'h51);
        wrst = 1'b0; wreq = 4'b1001; wlast = 4'b1001; set_data(0, 8'h80); set_data(3, 8'h83);
        idle_step("mrst after", 1'b0);
        beat_step("mrst regrant", 0, 8'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locking write-port arbiter for the FIFO memory.
- Shares the single write port (wdata/wclken) among NUM_REQ write-domain requesters.
- Gates writes against wfull and enforces a maximum burst length per grant.
- Sits in the wclk domain, between requesters and the memory/write-pointer logic; wclken doubles as the write-pointer increment.

Parameters:
DATA_WIDTH, 8, width of one FIFO word
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max beats per grant before forced release (1..255)

Ports:
wclk  input  1  write-domain clock; all logic on posedge
wrst  input  1  synchronous reset, active-high
wreq  input  NUM_REQ  per-requester beat valid
wlast  input  NUM_REQ  per-requester last beat of packet; qualified by wreq
wdata_in  input  NUM_REQ*DATA_WIDTH  requester data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
wfull  input  1  FIFO full flag from write-pointer logic
wgnt  output  NUM_REQ  one-hot grant; beat i accepted when wreq[i] && wgnt[i] && !wfull
wclken  output  1  memory write enable / pointer increment
wdata  output  DATA_WIDTH  muxed data to memory
owner  output  clog2(NUM_REQ)  current grant owner (valid when busy)
busy  output  1  grant held (state BUSY)
burst_err  output  1  one-cycle pulse on forced release at MAX_BURST

Behaviour:
- Clock and reset: single clock wclk. Reset is synchronous and active-high (wrst).
- Reset values:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, beat_cnt=0, burst_err=0.
  - Hence wgnt=0, wclken=0, busy=0.
  - wdata = wdata_in slice of owner (combinational mux; don't-care when wclken=0).
- State register: IDLE, BUSY.
- IDLE:
  - No grant; wclken=0.
  - If any wreq, pick the first set bit searching last_owner+1, +2, ... modulo NUM_REQ.
  - Register the pick as owner, clear beat_cnt, go to BUSY.
  - Arbitration latency: 1 cycle. A request seen in cycle t can transfer at the earliest in t+1.
- BUSY:
  - wgnt = one-hot(owner); busy=1.
  - Beat accepted when wreq[owner] && !wfull. Then wclken=1 in the same cycle, wdata = slice[owner], beat_cnt++.
  - Accepted beat with wlast[owner]=1: last_owner <= owner, go to IDLE.
  - Accepted beat with beat_cnt == MAX_BURST-1 and wlast=0: forced release. burst_err=1 next cycle for exactly one cycle, last_owner <= owner, go to IDLE. The requester must re-arbitrate for the rest of its packet.
  - wreq[owner]=0 without last: grant held (packet lock), no timeout, beat_cnt unchanged.
  - wfull=1: wclken=0, wgnt still asserted, state/beat_cnt unchanged. Stalls are unbounded.
- wclken is never 1 while wfull=1 or in IDLE.
- Requests from non-owners are ignored while BUSY. wlast without wreq is ignored.
- Fairness: a requester that just released is lowest priority in the next arbitration. With all NUM_REQ requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Throughput: one idle arbitration cycle between packets (accepted; no back-to-back re-grant).
- Reset mid-packet: next cycle returns IDLE, grant dropped, partial packet abandoned (already-written beats remain in FIFO), last_owner=NUM_REQ-1.
- beat_cnt width: clog2(MAX_BURST+1). No wrap possible, since release occurs at MAX_BURST.

Test Plan:
- Reset then wreq=4'b1111, each sends 1-beat packets (wlast=1) with data 8'hA0+i → grant order 0,1,2,3,0; each grant preceded by 1 IDLE cycle; wdata seen with wclken: A0,A1,A2,A3,A0.
- Requester 2 sends a 3-beat packet while requester 1 also requests → wgnt=4'b0100 for all 3 beats, no interleave; then owner=1 after 1 IDLE cycle.
- wfull=1 for 5 cycles mid-packet of requester 0 → wclken=0 for those 5 cycles, wgnt stays 4'b0001, beats resume with no data loss or duplication.
- MAX_BURST=4, requester 3 streams 6 beats, wlast only on beat 6 → 4 writes, burst_err pulses 1 cycle, IDLE, re-grant; remaining 2 beats written, no further burst_err.
- wrst asserted during beat 2 of a 4-beat packet → next cycle busy=0, wgnt=0, wclken=0; after release with wreq=4'b1001, requester 0 granted first.
- Owner drops wreq for 10 cycles without wlast while requester 1 requests → grant held by owner, wclken=0, requester 1 not granted until the owner's wlast beat.
